serial_addsub_seq: RTL and testbench
====================================

Name: serial_addsub_seq

Overview:
- Bit-serial N-bit add/subtract engine built around a single 1-bit full-adder/full-subtractor cell.
- The controller latches two operands and steps the cell once per clock, LSB first, for WIDTH clocks.
- It holds the running carry/borrow and returns the result with a start/done handshake.
- It is the sequencing layer over the gate-level adder/subtractor/comparator cells, and trades area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  operation request; accepted only when ready_o=1
- ready_o  output  1  high in IDLE; engine can accept start_i
- op_i  input  1  0=add (a+b), 1=sub (a-b); sampled at accept
- a_i  input  WIDTH  operand A, unsigned; sampled at accept
- b_i  input  WIDTH  operand B, unsigned; sampled at accept
- busy_o  output  1  high in RUN
- done_o  output  1  one-cycle pulse in DONE
- result_o  output  WIDTH  registered result; updated on RUN->DONE, then held
- cout_o  output  1  add: carry out of MSB; sub: borrow out (1 when a<b); updated with result_o

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ready_o=1; busy_o=0; done_o=0; result_o=0; cout_o=0; shift registers, bit counter and carry cleared.
- Reset mid-RUN or in DONE discards the partial operation. No done_o pulse is issued.

State IDLE:
- ready_o=1.
- On a clock edge with start_i=1: latch a_i, b_i and op_i into internal registers; bit counter=0; carry/borrow register=0; go to RUN.
- start_i=0: stay in IDLE.

State RUN:
- busy_o=1, ready_o=0.
- Each edge feeds bit [cnt] of the latched operands and the carry/borrow register to the 1-bit cell.
- The cell's sum/diff bit is shifted into the internal result register at the MSB, right-shifting, so bit 0 ends at the LSB after WIDTH shifts.
- The cell's carry/borrow out is stored; cnt increments.
- On the edge where cnt==WIDTH-1: copy the completed internal result to result_o, final carry/borrow to cout_o; go to DONE.

State DONE:
- done_o=1 for exactly one cycle; ready_o=0. Next edge goes to IDLE.

Timing and boundary rules:
- Latency: start accepted at edge E; done_o is high in the cycle after edge E+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start_i in RUN or DONE is ignored; it is not queued.
- a_i, b_i and op_i changes after accept have no effect.
- result_o and cout_o stay stable during RUN and hold until the next completion; they do not glitch through partial values.
- Arithmetic is modulo 2^WIDTH.
  - Add: {cout_o,result_o} = a+b.
  - Sub: result_o = (a-b) mod 2^WIDTH, cout_o = (a<b).
- Subtraction uses the full-subtractor form: diff = a^b^bin, bout = (~a&b)|(~(a^b)&bin). It is not two's-complement add.

Optional Feature:
- Macro: SERIAL_ADDSUB_CMP_FLAGS_EN.
- Defined: adds outputs eq_o, gt_o, lt_o (1 bit each), registered on the RUN->DONE edge and reset to 0.
  - For op=sub: eq_o = (result==0); lt_o = borrow; gt_o = ~borrow & ~eq.
  - For op=add: all three are 0.
- Not defined: the ports and the zero-detect logic are absent. Core behaviour is identical.

Decomposition:
- Shared package serial_addsub_pkg holds:
  - OP_ADD=1'b0, OP_SUB=1'b1
  - 2-bit state encodings: S_IDLE=0, S_RUN=1, S_DONE=2
- Sub-module: full_add_sub_bit, a combinational 1-bit cell.
  - Inputs a, b, cin, sub. Outputs s, cout.
  - Built from NAND gates, consistent with the existing adder/subtractor cells.
- Top contains the FSM, bit counter, operand shift registers and output registers.

Test Plan (WIDTH=8):
- Hold rst_n=0 for 3 cycles, release -> ready_o=1, busy_o=0, done_o=0, result_o=0, cout_o=0.
- add a=100, b=55, start for one cycle -> busy_o high for 8 cycles; done_o pulses 8 cycles after accept edge; result_o=155, cout_o=0; ready_o=1 the cycle after.
- add a=200, b=100 -> result_o=44, cout_o=1. add 255+1 -> result_o=0, cout_o=1.
- sub a=50, b=70 -> result_o=236, cout_o=1, lt_o=1 if flags enabled.
  - sub 70-70 -> result_o=0, cout_o=0, eq_o=1.
  - sub 90-20 -> result_o=70, gt_o=1.
- Accept add 10+20, then pulse start_i and change a_i=99 at cycle 3 of RUN -> second start ignored; result_o=30; exactly one done_o pulse.
- Accept sub 5-3, drop rst_n at cycle 4 of RUN -> immediate IDLE, result_o=0, no done_o. Then add 1+1 -> result_o=2.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract engine:
// operation encodings and controller state encodings.
package serial_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_seq_full_add_sub_bit.sv
// One-bit full adder / full subtractor cell, built only from 2-input NANDs.
// sub=0: s = a^b^cin, cout = a&b | (a^b)&cin
// sub=1: s = a^b^bin, bout = ~a&b | ~(a^b)&bin
// Both forms share one structure: invert a by sub before the generate and
// propagate terms (~a^b == ~(a^b)), while the sum/diff bit never sees sub.
module full_add_sub_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sub,
  output logic s,
  output logic cout
);

  // a ^ b
  logic n1, n2, n3, axb;
  assign n1  = ~(a & b);
  assign n2  = ~(a & n1);
  assign n3  = ~(b & n1);
  assign axb = ~(n2 & n3);

  // s = (a ^ b) ^ cin
  logic m1, m2, m3;
  assign m1 = ~(axb & cin);
  assign m2 = ~(axb & m1);
  assign m3 = ~(cin & m1);
  assign s  = ~(m2 & m3);

  // ax = a ^ sub : a for add, ~a for subtract
  logic k1, k2, k3, ax;
  assign k1 = ~(a & sub);
  assign k2 = ~(a & k1);
  assign k3 = ~(sub & k1);
  assign ax = ~(k2 & k3);

  // p = (a ^ b) ^ sub : propagate for add, ~(a ^ b) for subtract
  logic j1, j2, j3, p;
  assign j1 = ~(axb & sub);
  assign j2 = ~(axb & j1);
  assign j3 = ~(sub & j1);
  assign p  = ~(j2 & j3);

  // cout = (ax & b) | (p & cin)
  logic g_n, pc_n;
  assign g_n  = ~(ax & b);
  assign pc_n = ~(p & cin);
  assign cout = ~(g_n & pc_n);

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial WIDTH-bit add/subtract controller. Latches operands on start,
// steps a single 1-bit add/sub cell LSB first for WIDTH clocks, then
// publishes result/carry with a one-cycle done pulse.
// Optional comparison flags (eq_o/gt_o/lt_o) are built when
// SERIAL_ADDSUB_CMP_FLAGS_EN is defined.
// Handshake: start_i is taken on a rising edge only while ready_o=1; ready_o
// stays low from accept until the cycle after done_o; start_i at any other
// time is dropped, never queued.
module serial_addsub_seq
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             ready_o,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic [1:0]       state_o
`ifdef SERIAL_ADDSUB_CMP_FLAGS_EN
  ,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             op_q;

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] acc_next;

  // The operand registers shift right, so bit [cnt] always sits at bit 0.
  full_add_sub_bit u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sub  (op_q),
    .s    (cell_s),
    .cout (cell_c)
  );

  assign acc_next = {cell_s, acc[WIDTH-1:1]};
  assign state_o  = state;

  // Controller FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready_o  <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      cout_o   <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      op_q     <= OP_ADD;
`ifdef SERIAL_ADDSUB_CMP_FLAGS_EN
      eq_o     <= 1'b0;
      gt_o     <= 1'b0;
      lt_o     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_sh    <= a_i;
            b_sh    <= b_i;
            op_q    <= op_i;
            acc     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_next;
          carry <= cell_c;
          cnt   <= cnt + CW'(1);
          // Outputs only change here, so they never show partial sums.
          if (cnt == CW'(WIDTH - 1)) begin
            result_o <= acc_next;
            cout_o   <= cell_c;
`ifdef SERIAL_ADDSUB_CMP_FLAGS_EN
            eq_o <= (op_q == OP_SUB) && (acc_next == '0);
            lt_o <= (op_q == OP_SUB) && cell_c;
            gt_o <= (op_q == OP_SUB) && !cell_c && (acc_next != '0);
`endif
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Testbench for serial_addsub_seq (WIDTH=8). Flag outputs are connected and
// scored when SERIAL_ADDSUB_CMP_FLAGS_EN is defined.
module tb_serial_addsub_seq;
  import serial_addsub_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_i = 1'b0;
  logic         op_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         ready_o, busy_o, done_o, cout_o;
  logic [W-1:0] result_o;
  logic [1:0]   state_o;
`ifdef SERIAL_ADDSUB_CMP_FLAGS_EN
  logic         eq_o, gt_o, lt_o;
`endif

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .cout_o   (cout_o),
    .state_o  (state_o)
`ifdef SERIAL_ADDSUB_CMP_FLAGS_EN
    ,
    .eq_o     (eq_o),
    .gt_o     (gt_o),
    .lt_o     (lt_o)
`endif
  );

  // ---------------- checking ----------------
  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W:0]   exp_q[$];     // {cout, result}
  logic [2:0]   flag_q[$];    // {eq, gt, lt}
  logic [W-1:0] last_res = '0;
  int           done_count = 0;

  task automatic push_expected(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] e;
    logic [2:0] f;
    if (op == OP_SUB) begin
      e = {(a < b), W'(a - b)};
      f = {(a == b), (a > b), (a < b)};
    end else begin
      e = {1'b0, a} + {1'b0, b};
      f = 3'b000;
    end
    exp_q.push_back(e);
    flag_q.push_back(f);
  endtask

  // Pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      logic [W:0] e;
      logic [2:0] f;
      done_count++;
      if (exp_q.size() == 0) begin
        check("spurious_done", done_o, 0);
      end else begin
        e = exp_q.pop_front();
        f = flag_q.pop_front();
        check("result", result_o, e[W-1:0]);
        check("cout", cout_o, e[W]);
        last_res = e[W-1:0];
`ifdef SERIAL_ADDSUB_CMP_FLAGS_EN
        check("flags_eq_gt_lt", {eq_o, gt_o, lt_o}, f);
`else
        f = '0;
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int cyc = 0;
    while (!ready_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_start", ready_o, 1);
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    int busy_cyc;
    wait_ready();
    push_expected(op, a, b);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk);
    // Scramble inputs after accept; they must have no effect.
    start_i = 1'b0;
    op_i = ~op;
    a_i = W'($urandom);
    b_i = W'($urandom);
    check("ready_in_run", ready_o, 0);
    check("result_hold", result_o, last_res);
    cyc = 0;
    busy_cyc = 0;
    while (!done_o && cyc < W + 4) begin
      if (busy_o) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, W);
    check("busy_cycles", busy_cyc, W);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("ready_after_done", ready_o, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc;
    int cyc;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    check("rst_cout", cout_o, 0);
    check("rst_state", state_o, S_IDLE);

    run_op(OP_ADD, 8'd100, 8'd55);
    run_op(OP_ADD, 8'd200, 8'd100);
    run_op(OP_ADD, 8'd255, 8'd1);
    run_op(OP_SUB, 8'd50, 8'd70);
    run_op(OP_SUB, 8'd70, 8'd70);
    run_op(OP_SUB, 8'd90, 8'd20);
    run_op(OP_SUB, 8'd0, 8'd255);

    // start_i pulse and a_i change during RUN are ignored.
    wait_ready();
    dc = done_count;
    push_expected(OP_ADD, 8'd10, 8'd20);
    op_i = OP_ADD; a_i = 8'd10; b_i = 8'd20; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_i = 1'b1; a_i = 8'd99;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3 * W) @(negedge clk);
    check("ignored_start_done_count", done_count, dc + 1);
    check("ignored_start_idle", state_o, S_IDLE);

    // Reset in the middle of RUN discards the operation.
    wait_ready();
    dc = done_count;
    op_i = OP_SUB; a_i = 8'd5; b_i = 8'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_state", state_o, S_IDLE);
    check("midrun_rst_result", result_o, 0);
    check("midrun_rst_ready", ready_o, 1);
    check("midrun_rst_busy", busy_o, 0);
    last_res = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < W + 4) begin
      @(negedge clk);
      cyc++;
    end
    check("midrun_rst_no_done", done_count, dc);
    run_op(OP_ADD, 8'd1, 8'd1);

    // Random mix.
    for (int i = 0; i < 8; i++) begin
      run_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
